// File: rtl/fmv_src_scheduler_if.sv
// Handshake/config bundle between the FMV scheduler and its surroundings.
// Pure wiring: no latency of its own.
// No backpressure: strobes and pulses are single-cycle and never stalled.
interface fmv_src_scheduler_if #(
  parameter int XW = 9,
  parameter int YW = 9
);
  logic          enable;
  logic          cfg_vcd_mode;
  logic [XW-1:0] cfg_x_skip;
  logic [XW-1:0] cfg_width;
  logic [YW-1:0] cfg_lines;
  logic          frame_start;
  logic          line_start;
  logic          newpixel;
  logic          fifo_avail;
  logic          vcd_mode;
  logic          src_reset;
  logic          pix_pop;
  logic          pix_show;
  logic          pix_blank;
  logic [XW-1:0] pix_x;
  logic          frame_done;
  logic          underrun;

  // Driver side: timing generator, converter and FIFO status
  modport master (
    output enable, cfg_vcd_mode, cfg_x_skip, cfg_width, cfg_lines,
    output frame_start, line_start, newpixel, fifo_avail,
    input  vcd_mode, src_reset, pix_pop, pix_show, pix_blank, pix_x,
    input  frame_done, underrun
  );

  // Scheduler side
  modport slave (
    input  enable, cfg_vcd_mode, cfg_x_skip, cfg_width, cfg_lines,
    input  frame_start, line_start, newpixel, fifo_avail,
    output vcd_mode, src_reset, pix_pop, pix_show, pix_blank, pix_x,
    output frame_done, underrun
  );
endinterface

// File: rtl/fmv_src_scheduler.sv
// FMV sample-rate-converter sequencer: mode select, per-line phase reset, cropped FIFO pops.
// Latency: pop/show/blank/pix_x/frame_done combinational from newpixel; vcd_mode/src_reset one edge.
// Backpressure: none; an empty FIFO in the display window yields a blank slot and a sticky underrun.
module fmv_src_scheduler #(
  parameter int XW = 9,
  parameter int YW = 9
) (
  input  logic                  clk30_i,
  input  logic                  reset_n_i,
  fmv_src_scheduler_if.slave    bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WFRAME = 3'd1;
  localparam logic [2:0] ST_WLINE  = 3'd2;
  localparam logic [2:0] ST_SKIP   = 3'd3;
  localparam logic [2:0] ST_ACTIVE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          vcd_mode_q, vcd_mode_d;
  logic          src_reset_q, src_reset_d;
  logic          underrun_q, underrun_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] line_q, line_d;

  logic [XW-1:0] x_inc;
  logic [YW-1:0] line_inc;
  logic          quiet;     // enabled and no frame/line pulse this cycle
  logic          strobe;    // a newpixel that may be consumed
  logic          line_go;   // line_start that (re)starts a line this cycle
  logic          line_end;
  logic          pop, show, blank, fdone;

  assign x_inc    = x_q + XW'(1);
  assign line_inc = line_q + YW'(1);
  assign quiet    = bus.enable && !bus.frame_start && !bus.line_start;
  assign strobe   = quiet && bus.newpixel;

  // A frame_start with a coincident line_start starts line 0 at once; otherwise
  // line_start only matters while a line is pending or in progress.
  assign line_go = bus.enable && bus.line_start &&
                   (bus.frame_start ? (bus.cfg_lines != '0)
                                    : (state_q == ST_WLINE || state_q == ST_SKIP ||
                                       state_q == ST_ACTIVE));

  // Zero-latency pixel slot decode so the FIFO pops on the same edge as the strobe
  always_comb begin
    pop      = 1'b0;
    show     = 1'b0;
    blank    = 1'b0;
    line_end = 1'b0;
    if (state_q == ST_SKIP && strobe) begin
      pop = bus.fifo_avail;
    end
    if (state_q == ST_ACTIVE && quiet) begin
      if (bus.cfg_width == '0) begin
        line_end = 1'b1;
      end else if (bus.newpixel) begin
        show     = 1'b1;
        pop      = bus.fifo_avail;
        blank    = !bus.fifo_avail;
        line_end = (x_inc == bus.cfg_width);
      end
    end
  end

  assign fdone = line_end && (line_inc == bus.cfg_lines);

  // Next-state: frame_start reloads everything, line_start restarts the line, else walk the line
  always_comb begin
    state_d     = state_q;
    vcd_mode_d  = vcd_mode_q;
    src_reset_d = 1'b0;
    underrun_d  = underrun_q;
    x_d         = x_q;
    line_d      = line_q;
    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else if (bus.frame_start) begin
      vcd_mode_d  = bus.cfg_vcd_mode;
      src_reset_d = (bus.cfg_vcd_mode != vcd_mode_q);
      underrun_d  = 1'b0;
      line_d      = '0;
      state_d     = (bus.cfg_lines == '0) ? ST_WFRAME : ST_WLINE;
    end else if (!line_go) begin
      case (state_q)
        ST_IDLE: state_d = ST_WFRAME;
        ST_SKIP: begin
          if (strobe) begin
            if (x_inc == bus.cfg_x_skip) begin
              x_d     = '0;
              state_d = ST_ACTIVE;
            end else begin
              x_d = x_inc;
            end
          end
        end
        ST_ACTIVE: begin
          if (blank) underrun_d = 1'b1;
          if (line_end) begin
            line_d  = line_inc;
            state_d = fdone ? ST_WFRAME : ST_WLINE;
          end else if (show) begin
            x_d = x_inc;
          end
        end
        default: ;
      endcase
    end
    if (line_go) begin
      src_reset_d = 1'b1;
      x_d         = '0;
      state_d     = (bus.cfg_x_skip != '0) ? ST_SKIP : ST_ACTIVE;
    end
  end

  // State registers; the converter is held in reset while reset_n is low
  always_ff @(posedge clk30_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      vcd_mode_q  <= 1'b0;
      src_reset_q <= 1'b1;
      underrun_q  <= 1'b0;
      x_q         <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      vcd_mode_q  <= vcd_mode_d;
      src_reset_q <= src_reset_d;
      underrun_q  <= underrun_d;
      x_q         <= x_d;
      line_q      <= line_d;
    end
  end

  assign bus.vcd_mode   = vcd_mode_q;
  assign bus.src_reset  = src_reset_q;
  assign bus.underrun   = underrun_q;
  assign bus.pix_pop    = pop;
  assign bus.pix_show   = show;
  assign bus.pix_blank  = blank;
  assign bus.frame_done = fdone;
  assign bus.pix_x      = (state_q == ST_ACTIVE) ? x_q : '0;

endmodule

// File: doc/fmv_src_scheduler.md
# fmv_src_scheduler

Sequencer for the FMV sample rate converter. It decides when the converter runs in VCD (13.5 MHz) or base (30 MHz) mode, and it realigns the converter's phase at every display line. It consumes the converter's `newpixel` strobes and turns them into pixel pops from the decoded-picture FIFO. The FIFO read is cropped horizontally (skip, then width) and counted per line and per frame. FIFO underruns are flagged.

## Interface

Parameters:
- XW, 9, width of horizontal skip/width counters
- YW, 9, width of line counter

Ports:
- clk30  in  1  system clock, 30 MHz
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run request; low forces IDLE
- cfg_vcd_mode  in  1  requested converter mode; sampled only at frame_start
- cfg_x_skip  in  XW  pixels popped and discarded at line start
- cfg_width  in  XW  pixels displayed per line
- cfg_lines  in  YW  active lines per frame
- frame_start  in  1  one-cycle pulse, start of frame
- line_start  in  1  one-cycle pulse, start of display line
- newpixel  in  1  pixel strobe from the sample rate converter
- fifo_avail  in  1  decoded-picture FIFO holds at least one pixel
- vcd_mode  out  1  mode driven to the converter
- src_reset  out  1  active-high synchronous reset for the converter's accumulator
- pix_pop  out  1  one-cycle FIFO pop
- pix_show  out  1  with pix_pop or pix_blank: pixel is inside the display window
- pix_blank  out  1  display slot with no data; emit border colour
- pix_x  out  XW  index of the current displayed pixel, 0-based
- frame_done  out  1  one-cycle pulse after the last pixel of line cfg_lines-1
- underrun  out  1  sticky flag; cleared only at frame_start or reset

## Operation

States: IDLE, WAIT_FRAME, WAIT_LINE, SKIP, ACTIVE.

- **IDLE**
  - Entered from any state whenever enable=0; takes effect on the next edge.
  - Pops cease in the same cycle enable falls (outputs are gated combinationally by enable).
  - Leaves to WAIT_FRAME when enable=1.
- **WAIT_FRAME**
  - On frame_start:
    - vcd_mode <= cfg_vcd_mode.
    - underrun <= 0.
    - Line counter <= 0.
  - If cfg_lines=0, stays in WAIT_FRAME. Otherwise goes to WAIT_LINE.
- **WAIT_LINE**
  - On line_start: src_reset=1 for exactly one cycle, x counter <= 0.
  - Goes to SKIP if cfg_x_skip≠0. Otherwise goes to ACTIVE, or straight to line-end if cfg_width=0.
- **SKIP**
  - Each newpixel: pix_pop=1 if fifo_avail, with pix_show=0.
  - If fifo_avail=0, the strobe is lost silently: no underrun, no pop.
  - The x counter increments on every strobe. When it reaches cfg_x_skip, it clears and the state goes to ACTIVE.
- **ACTIVE**
  - Each newpixel with fifo_avail=1: pix_pop=1, pix_show=1, pix_x=x.
  - Each newpixel with fifo_avail=0: pix_blank=1, pix_show=1, underrun <= 1.
  - x increments on each strobe. After strobe cfg_width-1, the line ends.
- **Line end**
  - Line counter increments.
  - If it equals cfg_lines: frame_done=1 and the state goes to WAIT_FRAME.
  - Otherwise the state goes to WAIT_LINE.
- **Mode change:** when the vcd_mode latched at frame_start differs from its previous value, src_reset is also asserted in that frame_start cycle.
- **frame_start outside WAIT_FRAME** (while enabled): treated as in WAIT_FRAME. The current line is abandoned, the mode and counters are reloaded, and the state goes to WAIT_LINE. No frame_done is issued.
- **line_start during SKIP or ACTIVE:** the current line is abandoned without counting it. The line restarts as in WAIT_LINE with the same line index.
- **line_start in WAIT_FRAME:** ignored.

## Timing

- Reset values while reset_n=0:
  - State IDLE.
  - vcd_mode=0; src_reset=1 (converter held in reset).
  - pix_pop, pix_show, pix_blank, frame_done, underrun = 0; pix_x=0.
- src_reset drops on the first clk30 edge after reset_n rises.
- pix_pop, pix_blank, pix_show and pix_x are combinational from newpixel and the registered state.
  - They are asserted in the same cycle as newpixel.
  - Zero latency, so the FIFO pops on the same edge.
- frame_done is asserted in the same cycle as the final ACTIVE strobe.
- src_reset and vcd_mode are registered: they change one edge after line_start or frame_start.
- Simultaneous events:
  - frame_start and line_start in the same cycle: frame_start is processed, then that line_start starts line 0 (src_reset=1, next state SKIP or ACTIVE).
  - newpixel coincident with line_start or frame_start: ignored, no pop and no blank.
- Counters compare with equality only. cfg_* values are not range-checked and must be static outside WAIT_FRAME.
- A pixel strobe is never counted twice and never dropped in ACTIVE: every strobe produces exactly one pop or one blank.

## Test plan

- **Reset:** reset_n low for 3 cycles, with newpixel toggling.
  - During reset: all outputs 0 except src_reset=1.
  - First edge after release: src_reset=0.
- **Basic frame:** enable=1, cfg_vcd_mode=1, skip=7, width=345, lines=2, fifo_avail=1.
  - vcd_mode=1 after frame_start.
  - Per line: 352 pops; pix_show=1 on exactly the last 345 of them, pix_x 0..344.
  - frame_done pulses once, on the 345th shown strobe of line 1.
- **Underrun:** fifo_avail=0 for 3 strobes in mid-ACTIVE.
  - 3 pix_blank pulses, pix_x keeps advancing, underrun=1.
  - underrun stays 1 until the next frame_start, then reads 0.
- **Mode change:** cfg_vcd_mode flips 0→1 mid-frame.
  - vcd_mode stays unchanged until the next frame_start.
  - At that frame_start, src_reset pulses once, then vcd_mode=1.
- **Abandon:** line_start arrives after 100 ACTIVE strobes.
  - Line index unchanged, x=0, src_reset pulses, SKIP re-entered.
  - frame_done pulses only after cfg_lines complete lines.
- **Corner cases:** width=0, skip=0, lines=1, frame_start and line_start coincident.
  - No pops.
  - frame_done on the cycle after line_start.
  - Then WAIT_FRAME; enable low there gives IDLE on the next edge.
